// File: rtl/apb_uart_ctrl.sv
`timescale 1ns/1ps
// apb_uart_ctrl
//   APB3 slave UART with TX/RX FIFOs, runtime baud divisor, optional even/odd
//   parity, sticky error flags, PSLVERR and a registered level interrupt.
// Ports
//   PCLK, PRESET       clock, asynchronous active-high reset
//   PADDR..PENABLE     APB3 request (PADDR[4:2] selects the register)
//   PRDATA/PREADY      read data / ready (zero wait states)
//   PSLVERR            error response, valid with PREADY
//   rx, tx             serial in (asynchronous, idle high) / serial out (idle high)
//   irq                level interrupt
module apb_uart_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RESET  = 650
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullLvl = CW'(FIFO_DEPTH);

  localparam logic [2:0] RegStatus = 3'd0;
  localparam logic [2:0] RegCtrl   = 3'd1;
  localparam logic [2:0] RegTxData = 3'd2;
  localparam logic [2:0] RegRxData = 3'd3;
  localparam logic [2:0] RegBaud   = 3'd4;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // ---------------- APB decode ----------------
  logic [2:0] sel;
  logic       access, wr_acc, rd_acc;
  logic       unused_bits;

  assign sel         = PADDR[4:2];
  assign access      = PSEL & PENABLE;
  assign wr_acc      = access & PWRITE;
  assign rd_acc      = access & ~PWRITE;
  assign PREADY      = access;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // ---------------- Control registers ----------------
  logic [6:0]       ctrl_q;
  logic [DIV_W-1:0] div_q, baud_cnt_q;
  logic             tx_en, rx_en, par_en, par_odd, ie_rx, ie_txe, ie_err;
  logic             div_wr, tick16;

  assign tx_en   = ctrl_q[0];
  assign rx_en   = ctrl_q[1];
  assign par_en  = ctrl_q[2];
  assign par_odd = ctrl_q[3];
  assign ie_rx   = ctrl_q[4];
  assign ie_txe  = ctrl_q[5];
  assign ie_err  = ctrl_q[6];
  assign div_wr  = wr_acc && (sel == RegBaud);
  assign tick16  = (baud_cnt_q == div_q);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q     <= 7'h03;
      div_q      <= DIV_W'(DIV_RESET);
      baud_cnt_q <= '0;
    end else begin
      if (wr_acc && (sel == RegCtrl)) ctrl_q <= PWDATA[6:0];
      if (div_wr) div_q <= PWDATA[DIV_W-1:0];
      // A divisor write restarts the bit-rate counter so the new rate starts cleanly.
      if (div_wr || tick16) baud_cnt_q <= '0;
      else                  baud_cnt_q <= baud_cnt_q + 1'b1;
    end
  end

  // ---------------- FIFOs ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]    tx_head, rx_sh_q;

  assign tx_full  = (tx_cnt_q == FullLvl);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FullLvl);
  assign rx_empty = (rx_cnt_q == '0);
  // Fullness/emptiness are the registered values, so a same-cycle pop never
  // makes room for a push (and vice versa).
  assign tx_push  = wr_acc && (sel == RegTxData) && !tx_full;
  assign rx_pop   = rd_acc && (sel == RegRxData) && !rx_empty;
  assign tx_head  = tx_mem[tx_rd_q];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr_q] <= PWDATA[7:0];
    if (rx_push) rx_mem[rx_wr_q] <= rx_sh_q;
  end

  // ---------------- TX FSM ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_pen_d   = tx_pen_q;
    tx_pop     = 1'b0;
    if (tx_state_q == TxIdle) begin
      // tx_en is only consulted here, so clearing it lets the current frame finish.
      if (tick16 && tx_en && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_d    = tx_head;
        tx_par_d   = (^tx_head) ^ par_odd;
        tx_pen_d   = par_en;
        tx_tick_d  = '0;
        tx_bit_d   = '0;
        tx_state_d = TxStart;
      end
    end else if (tick16) begin
      tx_tick_d = tx_tick_q + 4'd1;
      if (tx_tick_q == 4'd15) begin
        unique case (tx_state_q)
          TxStart: tx_state_d = TxData;
          TxData: begin
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = tx_pen_q ? TxParity : TxStop;
          end
          TxParity: tx_state_d = TxStop;
          default:  tx_state_d = TxIdle;
        endcase
      end
    end
  end

  // Output decoded from state so reset forces the line idle without a clock.
  always_comb begin
    tx = 1'b1;
    unique case (tx_state_q)
      TxStart:  tx = 1'b0;
      TxData:   tx = tx_sh_q[0];
      TxParity: tx = tx_par_q;
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_state_q <= TxIdle;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_pen_q   <= tx_pen_d;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_d;
  logic       rx_pbit_q, rx_pbit_d;
  logic       rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  logic       set_ovr, set_frm, set_par;

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_pbit_d  = rx_pbit_q;
    rx_push    = 1'b0;
    set_ovr    = 1'b0;
    set_frm    = 1'b0;
    set_par    = 1'b0;
    if (!rx_en) begin
      rx_state_d = RxIdle;
    end else if (rx_state_q == RxIdle) begin
      if (rx_fall) begin
        rx_state_d = RxStart;
        rx_tick_d  = '0;
        rx_bit_d   = '0;
      end
    end else if (tick16) begin
      rx_tick_d = rx_tick_q + 4'd1;
      if (rx_tick_q == 4'd7) begin
        // Mid-cell sample point.
        unique case (rx_state_q)
          RxStart:  if (rx_s2_q) rx_state_d = RxIdle;
          RxData:   rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          RxParity: rx_pbit_d = rx_s2_q;
          default: begin
            rx_state_d = RxIdle;
            if (!rx_s2_q) begin
              set_frm = 1'b1;
            end else begin
              if (par_en && (rx_pbit_q != ((^rx_sh_q) ^ par_odd))) set_par = 1'b1;
              if (rx_full) set_ovr = 1'b1;
              else         rx_push = 1'b1;
            end
          end
        endcase
      end else if (rx_tick_q == 4'd15) begin
        unique case (rx_state_q)
          RxStart: begin
            rx_state_d = RxData;
            rx_bit_d   = '0;
          end
          RxData: begin
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = par_en ? RxParity : RxStop;
          end
          RxParity: rx_state_d = RxStop;
          default:  rx_state_d = RxIdle;
        endcase
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pbit_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pbit_q  <= rx_pbit_d;
    end
  end

  // ---------------- Flags, interrupt, read mux ----------------
  logic       ovr_q, frm_q, par_q, irq_q, irq_d;
  logic [2:0] clr_bits;
  logic [31:0] status_word, rdata;
  logic        err;

  assign clr_bits = (wr_acc && (sel == RegStatus)) ? PWDATA[6:4] : 3'b000;
  assign irq_d    = (ie_rx & ~rx_empty) | (ie_txe & tx_empty) | (ie_err & (ovr_q | frm_q | par_q));
  assign irq      = irq_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
      par_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      // A new event wins over a simultaneous W1C.
      ovr_q <= (ovr_q & ~clr_bits[0]) | set_ovr;
      frm_q <= (frm_q & ~clr_bits[1]) | set_frm;
      par_q <= (par_q & ~clr_bits[2]) | set_par;
      irq_q <= irq_d;
    end
  end

  assign status_word = {8'(rx_cnt_q), 8'(tx_cnt_q), 9'd0, par_q, frm_q, ovr_q,
                        rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    rdata = '0;
    err   = 1'b0;
    case (sel)
      RegStatus: rdata = status_word;
      RegCtrl:   rdata = {25'd0, ctrl_q};
      RegTxData: err = PWRITE & tx_full;
      RegRxData: begin
        if (!PWRITE) begin
          if (rx_empty) err = 1'b1;
          else          rdata = {24'd0, rx_mem[rx_rd_q]};
        end
      end
      RegBaud:   rdata = 32'(div_q);
      default:   err = 1'b1;
    endcase
  end

  assign PRDATA  = rd_acc ? rdata : 32'd0;
  assign PSLVERR = access & err;

endmodule

// File: tb/tb_apb_uart_ctrl.sv
`timescale 1ns/1ps
module tb_apb_uart_ctrl;
  localparam int DEPTH = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        rx;
  logic        tx, irq;

  always #5 PCLK = ~PCLK;

  apb_uart_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(650)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .rx(rx), .tx(tx), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] rxq[$];
  bit m_ovr, m_frm, m_par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic err,
                          output logic rdy);
    @(posedge PCLK); #1;
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 d = PRDATA; err = PSLVERR; rdy = PREADY;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Serial frame, index 0 first on the wire.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit pen, input bit podd,
                                             input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    f[8:1] = b;
    if (pen) begin
      f[9]  = (^b) ^ podd ^ bad_par;
      f[10] = ~bad_stop;
    end else begin
      f[9] = ~bad_stop;
    end
    return f;
  endfunction

  function automatic logic [31:0] exp_status(input int txl);
    int rxl;
    rxl = rxq.size();
    return {8'(rxl), 8'(txl), 9'd0, m_par, m_frm, m_ovr,
            rxl == DEPTH, rxl == 0, txl == DEPTH, txl == 0};
  endfunction

  task automatic check_status(input string tag, input int txl);
    logic [31:0] d; logic e, r;
    apb_read(5'h00, d, e, r);
    check(tag, d, exp_status(txl));
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d; logic e, r;
    apb_read(5'h0C, d, e, r);
    if (rxq.size() == 0) begin
      check({tag, "_err"}, 32'(e), 32'd1);
      check({tag, "_data"}, d, 32'd0);
    end else begin
      check({tag, "_err"}, 32'(e), 32'd0);
      check({tag, "_data"}, d, {24'd0, rxq.pop_front()});
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit pen, input bit podd,
                         input bit bad_par, input bit bad_stop);
    logic [10:0] f; int n;
    f = frame_bits(b, pen, podd, bad_par, bad_stop);
    n = pen ? 11 : 10;
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      repeat (64) @(posedge PCLK);
      #1;
    end
    rx = 1'b1;
    repeat (32) @(posedge PCLK);
    #1;
    if (bad_stop) m_frm = 1'b1;
    else begin
      if (pen && bad_par) m_par = 1'b1;
      if (rxq.size() == DEPTH) m_ovr = 1'b1;
      else rxq.push_back(b);
    end
  endtask

  // Wait for a start bit, then sample every cell at its centre (DIV=3: 64 PCLK/bit).
  task automatic check_tx_frame(input logic [7:0] b, input bit pen, input bit podd,
                                input bit measure, input string tag);
    logic [10:0] f; int n, k, first;
    f = frame_bits(b, pen, podd, 1'b0, 1'b0);
    n = pen ? 11 : 10;
    k = 0;
    while (tx !== 1'b0 && k < 2000) begin
      @(posedge PCLK); #1; k++;
    end
    check({tag, "_start_seen"}, 32'(tx === 1'b0), 32'd1);
    if (tx !== 1'b0) return;
    first = 0;
    if (measure) begin
      k = 0;
      while (tx === 1'b0 && k < 200) begin
        @(posedge PCLK); #1; k++;
      end
      check({tag, "_start_len"}, 32'(k), 32'd64);
      first = 1;
    end
    repeat (32) @(posedge PCLK);
    #1;
    for (int i = first; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(f[i]));
      if (i < n - 1) begin
        repeat (64) @(posedge PCLK);
        #1;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
             errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic e, r;
    logic [7:0] b;
    logic [7:0] txb[$];
    int k;

    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0; rx = 1'b1; PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    apb_read(5'h00, d, e, r);
    check("rst_status", d, 32'h0000_0005);
    check("pready", 32'(r), 32'd1);
    apb_read(5'h04, d, e, r);
    check("rst_ctrl", d, 32'h03);
    apb_read(5'h10, d, e, r);
    check("rst_div", d, 32'd650);
    apb_read(5'h14, d, e, r);
    check("hole_rd_err", 32'(e), 32'd1);
    check("hole_rd_data", d, 32'd0);
    apb_write(5'h1C, 32'hFFFF_FFFF, e);
    check("hole_wr_err", 32'(e), 32'd1);
    apb_read(5'h04, d, e, r);
    check("hole_wr_ignored", d, 32'h03);

    // TX: fixed pattern at DIV=3, then a random byte with odd parity.
    apb_write(5'h10, 32'd3, e);
    apb_read(5'h10, d, e, r);
    check("div_wr", d, 32'd3);
    apb_write(5'h08, 32'hA5, e);
    check("tx_wr_err", 32'(e), 32'd0);
    check_tx_frame(8'hA5, 1'b0, 1'b0, 1'b1, "txa5");
    repeat (40) @(posedge PCLK);
    #1;
    check_status("after_tx", 0);
    apb_write(5'h04, 32'h0F, e);
    b = 8'($urandom_range(0, 255));
    apb_write(5'h08, {24'd0, b}, e);
    check_tx_frame(b, 1'b1, 1'b1, 1'b0, "txpar");
    repeat (40) @(posedge PCLK);
    #1;

    // RX with even parity: bad parity keeps the byte, sets par, W1C clears.
    apb_write(5'h04, 32'h07, e);
    send_rx(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    check_status("rx_badpar_status", 0);
    read_rx("rx_5a");
    apb_write(5'h00, 32'h40, e);
    m_par = 1'b0;
    check_status("par_w1c", 0);
    send_rx(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, 1'b0);
    check_status("rx_goodpar_status", 0);
    read_rx("rx_goodpar");

    // Framing error: byte discarded, irq follows ie_err one cycle late.
    apb_write(5'h04, 32'h03, e);
    send_rx(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b1);
    check("frm_irq_masked", 32'(irq), 32'd0);
    check_status("frm_status", 0);
    apb_write(5'h04, 32'h43, e);
    check("irq_lag", 32'(irq), 32'd0);
    @(posedge PCLK); #1;
    check("irq_err", 32'(irq), 32'd1);
    apb_write(5'h00, 32'h70, e);
    m_frm = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check("irq_cleared", 32'(irq), 32'd0);
    apb_write(5'h04, 32'h03, e);

    // RX overflow: DEPTH+1 frames, no reads.
    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'($urandom_range(0, 255)), 1'b0, 1'b0,
                                                 1'b0, 1'b0);
    check_status("rx_ovr_status", 0);
    apb_write(5'h04, 32'h13, e);
    repeat (2) @(posedge PCLK);
    #1;
    check("irq_rx", 32'(irq), 32'd1);
    for (int i = 0; i < DEPTH; i++) read_rx($sformatf("rx_drain%0d", i));
    read_rx("rx_empty_read");
    check_status("rx_drained_status", 0);
    apb_write(5'h04, 32'h03, e);

    // TX FIFO fill with transmitter disabled.
    apb_write(5'h04, 32'h02, e);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom_range(0, 255));
      apb_write(5'h08, {24'd0, b}, e);
      if (i < DEPTH) txb.push_back(b);
      check($sformatf("tx_fill_err%0d", i), 32'(e), (i < DEPTH) ? 32'd0 : 32'd1);
    end
    check_status("tx_full_status", DEPTH);
    apb_write(5'h04, 32'h03, e);
    check_tx_frame(txb[0], 1'b0, 1'b0, 1'b0, "txq0");

    // Reset in the middle of the next start bit.
    k = 0;
    while (tx !== 1'b0 && k < 2000) begin
      @(posedge PCLK); #1; k++;
    end
    repeat (10) @(posedge PCLK);
    #1;
    check("tx_second_frame_low", 32'(tx), 32'd0);
    PRESET = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    rxq.delete();
    m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
    check_status("post_rst_status", 0);
    apb_read(5'h10, d, e, r);
    check("post_rst_div", d, 32'd650);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
